// File: rtl/sobel_window_gen_pkg.sv
// Shared constants and window index names for the sobel window producer.
package sobel_window_gen_pkg;

  localparam int IMG_WIDTH   = 640;
  localparam int PIX_W_DEF   = 8;
  localparam int COORD_W_DEF = 10;

  typedef enum logic [3:0] {
    Z_TL = 4'd0, Z_TC = 4'd1, Z_TR = 4'd2,
    Z_ML = 4'd3, Z_MC = 4'd4, Z_MR = 4'd5,
    Z_BL = 4'd6, Z_BC = 4'd7, Z_BR = 4'd8
  } win_idx_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_ram.sv
// Two-line history RAM: each word packs {row r-2, row r-1} for one column.
// Simple dual-port with registered read; a read to the address being written returns the old word.
module sobel_line_ram #(
  parameter int DEPTH = 640,
  parameter int W     = 16,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_window_gen.sv
// Builds a sliding 3x3 luma window from a raster stream for the sobel stage.
// Column history is written back one cycle late; a bypass covers back-to-back hits on one column.
module sobel_window_gen #(
  parameter int IMG_WIDTH = sobel_window_gen_pkg::IMG_WIDTH,
  parameter int PIX_W     = sobel_window_gen_pkg::PIX_W_DEF,
  parameter int COORD_W   = sobel_window_gen_pkg::COORD_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_valid,
  input  logic               sof,
  input  logic               sol,
  output logic [PIX_W-1:0]   z0,
  output logic [PIX_W-1:0]   z1,
  output logic [PIX_W-1:0]   z2,
  output logic [PIX_W-1:0]   z3,
  output logic [PIX_W-1:0]   z4,
  output logic [PIX_W-1:0]   z5,
  output logic [PIX_W-1:0]   z6,
  output logic [PIX_W-1:0]   z7,
  output logic [PIX_W-1:0]   z8,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y
);

  import sobel_window_gen_pkg::*;

  localparam int                 AW       = addr_w(IMG_WIDTH);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] ROW_MAX  = '1;
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic               s1_valid_q;
  logic [PIX_W-1:0]   pix_q;
  logic               hit_q, hit_d;
  logic [2*PIX_W-1:0] byp_q;
  logic [2*PIX_W-1:0] ram_rd, rd_eff, ram_wr;
  logic [PIX_W-1:0]   win_q [9];
  logic [PIX_W-1:0]   win_d [9];
  logic               win_valid_q, win_valid_d;
  logic [COORD_W-1:0] win_x_q, win_x_d, win_y_q, win_y_d;

  // Coordinates the current pixel takes if it is accepted this cycle.
  always_comb begin
    col_d = col_q + ONE;
    row_d = row_q;
    if (sof) begin
      col_d = '0;
      row_d = '0;
    end else if (sol || (col_q == LAST_COL)) begin
      col_d = '0;
      row_d = (row_q == ROW_MAX) ? row_q : row_q + ONE;
    end
  end

  assign rd_eff = hit_q ? byp_q : ram_rd;
  assign ram_wr = {rd_eff[PIX_W-1:0], pix_q};
  assign hit_d  = pix_valid && s1_valid_q && (col_d[AW-1:0] == col_q[AW-1:0]);

  sobel_line_ram #(
    .DEPTH (IMG_WIDTH),
    .W     (2*PIX_W),
    .AW    (AW)
  ) u_line_ram (
    .clock     (clock),
    .wr_en_i   (s1_valid_q),
    .wr_addr_i (col_q[AW-1:0]),
    .wr_data_i (ram_wr),
    .rd_en_i   (pix_valid),
    .rd_addr_i (col_d[AW-1:0]),
    .rd_data_o (ram_rd)
  );

  always_comb begin
    win_d       = win_q;
    win_valid_d = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    if (s1_valid_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[int'(Z_TR)] = rd_eff[2*PIX_W-1:PIX_W];
      win_d[int'(Z_MR)] = rd_eff[PIX_W-1:0];
      win_d[int'(Z_BR)] = pix_q;
      win_valid_d       = (col_q >= TWO) && (row_q >= TWO);
      win_x_d           = col_q - ONE;
      win_y_d           = row_q - ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      s1_valid_q  <= 1'b0;
      pix_q       <= '0;
      hit_q       <= 1'b0;
      byp_q       <= '0;
      win_valid_q <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      if (pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        pix_q <= pix_in;
      end
      s1_valid_q  <= pix_valid;
      hit_q       <= hit_d;
      byp_q       <= ram_wr;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
    end
  end

  assign z0        = win_q[int'(Z_TL)];
  assign z1        = win_q[int'(Z_TC)];
  assign z2        = win_q[int'(Z_TR)];
  assign z3        = win_q[int'(Z_ML)];
  assign z4        = win_q[int'(Z_MC)];
  assign z5        = win_q[int'(Z_MR)];
  assign z6        = win_q[int'(Z_BL)];
  assign z7        = win_q[int'(Z_BC)];
  assign z8        = win_q[int'(Z_BR)];
  assign win_valid = win_valid_q;
  assign win_x     = win_x_q;
  assign win_y     = win_y_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised bench for sobel_window_gen at a 4-pixel line width against a column-history model.
module tb_sobel_window_gen;

  localparam int W   = 4;
  localparam int PW  = 8;
  localparam int CW  = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [PW-1:0] pix_in;
  logic          pix_valid, sof, sol;
  logic [PW-1:0] z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic          win_valid;
  logic [CW-1:0] win_x, win_y;
  logic [71:0]   dut_z;

  assign dut_z = {z0, z1, z2, z3, z4, z5, z6, z7, z8};

  sobel_window_gen #(.IMG_WIDTH(W), .PIX_W(PW), .COORD_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .sof(sof), .sol(sol),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: per-column history of the last two lines that reached the column,
  // plus the last three column triples forming the window.
  logic [7:0] hist1 [W];
  logic [7:0] hist2 [W];
  logic [7:0] mwin  [9];
  int  m_col, m_row, m_x, m_y;
  bit  m_valid;
  bit  p_v;
  int  p_c, p_r;
  logic [7:0] p_top, p_mid, p_pix;

  int  dut_pulses;
  int  qx[$];
  int  qy[$];
  logic [71:0] qz[$];
  bit  sobel_mode;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mwin[i] = 8'h00;
    m_valid = 0; p_v = 0; m_col = 0; m_row = 0; m_x = 0; m_y = 0;
  endtask

  task automatic model_clock(input bit pv, input bit s_of, input bit s_ol, input logic [7:0] px);
    int c, r;
    if (p_v) begin
      for (int k = 0; k < 3; k++) begin
        mwin[3*k]   = mwin[3*k+1];
        mwin[3*k+1] = mwin[3*k+2];
      end
      mwin[2] = p_top; mwin[5] = p_mid; mwin[8] = p_pix;
      m_valid = (p_c >= 2) && (p_r >= 2);
      m_x = p_c - 1; m_y = p_r - 1;
    end else begin
      m_valid = 0;
    end
    p_v = pv;
    if (pv) begin
      if (s_of) begin
        c = 0; r = 0;
      end else if (s_ol || m_col == W - 1) begin
        c = 0; r = (m_row == 1023) ? m_row : m_row + 1;
      end else begin
        c = m_col + 1; r = m_row;
      end
      p_top = hist2[c]; p_mid = hist1[c]; p_pix = px;
      hist2[c] = hist1[c]; hist1[c] = px;
      m_col = c; m_row = r; p_c = c; p_r = r;
    end
  endtask

  function automatic int sobel_mag(input logic [71:0] zz);
    int z [9];
    int gx, gy, m;
    for (int i = 0; i < 9; i++) z[i] = int'(zz[71-8*i -: 8]);
    gx = (z[2] + 2*z[5] + z[8]) - (z[0] + 2*z[3] + z[6]);
    gy = (z[6] + 2*z[7] + z[8]) - (z[0] + 2*z[1] + z[2]);
    m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
  task automatic step(input bit pv, input bit s_of, input bit s_ol, input logic [7:0] px);
    pix_valid = pv; sof = s_of; sol = s_ol; pix_in = px;
    @(posedge clock);
    model_clock(pv, s_of, s_ol, px);
    @(negedge clock);
    check("win_valid", 72'(win_valid), 72'(m_valid));
    if (m_valid) begin
      check("window", dut_z, {mwin[0], mwin[1], mwin[2], mwin[3], mwin[4],
                              mwin[5], mwin[6], mwin[7], mwin[8]});
      check("win_x", 72'(win_x), 72'(m_x));
      check("win_y", 72'(win_y), 72'(m_y));
    end
    if (win_valid) begin
      dut_pulses++;
      qx.push_back(int'(win_x)); qy.push_back(int'(win_y)); qz.push_back(dut_z);
      $display("win x=%0d y=%0d z=%h", win_x, win_y, dut_z);
      if (sobel_mode) check("sobel_edge", 72'(sobel_mag(dut_z)), 72'hff);
    end
  endtask

  task automatic clear_log();
    dut_pulses = 0;
    qx.delete(); qy.delete(); qz.delete();
  endtask

  // Sends the first n pixels of a 4x4 frame; mode 0: base|(r<<4)|c, mode 1: vertical step.
  task automatic send_frame(input logic [7:0] base, input int max_gap, input int n, input int mode);
    logic [7:0] px;
    for (int i = 0; i < n; i++) begin
      int r, c, g;
      r = i / W; c = i % W;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) step(0, 0, 0, 8'($urandom));
      px = (mode == 1) ? ((c < 2) ? 8'h00 : 8'hff) : (base | 8'(r << 4) | 8'(c));
      step(1, i == 0, 0, px);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_z"}, dut_z, 72'h0);
    check({tag, "_valid"}, 72'(win_valid), 72'h0);
    check({tag, "_x"}, 72'(win_x), 72'h0);
    check({tag, "_y"}, 72'(win_y), 72'h0);
  endtask

  initial begin
    for (int i = 0; i < W; i++) begin hist1[i] = 8'h00; hist2[i] = 8'h00; end
    sobel_mode = 0;
    model_reset();
    reset_n = 1'b0; pix_valid = 0; sof = 0; sol = 0; pix_in = 8'h00;
    repeat (2) @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // 1: continuous frame
    clear_log();
    send_frame(8'h00, 0, 16, 0); idle(3);
    check("t1_pulses", 72'(dut_pulses), 72'd4);
    if (qz.size() > 0) begin
      check("t1_first_z", qz[0], 72'h000102101112202122);
      check("t1_first_x", 72'(qx[0]), 72'd1);
      check("t1_first_y", 72'(qy[0]), 72'd1);
    end else check("t1_first_seen", 72'(qz.size()), 72'd1);

    // 2: random idle gaps
    clear_log();
    send_frame(8'h00, 3, 16, 0); idle(3);
    check("t2_pulses", 72'(dut_pulses), 72'd4);

    // 3: sof reasserted at (2,1)
    clear_log();
    send_frame(8'h00, 0, 6, 0);
    send_frame(8'h80, 0, 16, 0); idle(3);
    check("t3_pulses", 72'(dut_pulses), 72'd4);
    if (qz.size() > 0) check("t3_first_z", qz[0], 72'h808182909192a0a1a2);

    // 4: reset after pixel (3,2)
    clear_log();
    send_frame(8'h00, 0, 12, 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_zero("t4_async");
    @(negedge clock);
    check_zero("t4_held");
    reset_n = 1'b1;
    clear_log();
    send_frame(8'h40, 1, 16, 0); idle(3);
    check("t4_pulses", 72'(dut_pulses), 72'd4);

    // 5: sol after column 2 of row 2
    clear_log();
    send_frame(8'h00, 0, 11, 0);
    step(1, 0, 1, 8'h30); step(1, 0, 0, 8'h31);
    step(1, 0, 0, 8'h32); step(1, 0, 0, 8'h33); idle(3);
    check("t5_pulses", 72'(dut_pulses), 72'd3);
    if (qx.size() > 1) begin
      check("t5_x", 72'(qx[1]), 72'd1);
      check("t5_y", 72'(qy[1]), 72'd2);
    end else check("t5_seen", 72'(qx.size()), 72'd3);

    // 6: vertical step image
    clear_log();
    sobel_mode = 1;
    send_frame(8'h00, 0, 16, 1); idle(3);
    sobel_mode = 0;
    check("t6_pulses", 72'(dut_pulses), 72'd4);

    // Random traffic: gaps, early sol, sof restarts, back-to-back column-0 pixels
    clear_log();
    send_frame(8'h00, 0, 16, 0);
    for (int i = 0; i < 400; i++) begin
      bit pv, s_of, s_ol;
      pv   = ($urandom_range(3, 0) != 0);
      s_of = ($urandom_range(39, 0) == 0);
      s_ol = ($urandom_range(9, 0) == 0);
      step(pv, s_of, s_ol, 8'($urandom));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
